// File: rtl/synth_pkg.sv
// Shared definitions for the multi-voice phase accumulator.
//   state_t               : scheduler FSM state encoding (IDLE / COMPUTE / OUTPUT)
//   C_VOICES_DEFAULT      : default number of time-multiplexed voices
//   C_PHASE_WIDTH_DEFAULT : default width of phase and frequency words
package synth_pkg;

  localparam int C_VOICES_DEFAULT      = 16;
  localparam int C_PHASE_WIDTH_DEFAULT = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    OUTPUT  = 2'd2
  } state_t;

endpackage : synth_pkg

// File: rtl/cl_adder.sv
// Unsigned adder with carry in and carry out.
//   a, b : C_WIDTH-bit operands
//   cin  : carry in
//   sum  : C_WIDTH-bit sum (mod 2^C_WIDTH)
//   cout : carry out (bit C_WIDTH of the full-precision result)
// Written behaviourally so synthesis can choose the carry structure.
module cl_adder #(
  parameter int C_WIDTH = 32
) (
  input  logic [C_WIDTH-1:0] a,
  input  logic [C_WIDTH-1:0] b,
  input  logic               cin,
  output logic [C_WIDTH-1:0] sum,
  output logic               cout
);

  logic [C_WIDTH:0] full_s;

  // Full-precision sum; the extra MSB is the carry out.
  always_comb begin
    full_s = {1'b0, a} + {1'b0, b} + {{C_WIDTH{1'b0}}, cin};
  end

  assign sum  = full_s[C_WIDTH-1:0];
  assign cout = full_s[C_WIDTH];

endmodule : cl_adder

// File: rtl/phase_acc_multi.sv
// Time-multiplexed phase accumulator for C_VOICES voices.
// Each slot takes two cycles: COMPUTE reads the voice's phase and
// frequency and registers phase+freq, OUTPUT presents the pre-increment
// phase with a valid/ready handshake and writes the sum back on accept.
//   clk, reset_n   : clock, synchronous active-low reset
//   enable         : run request for the voice scheduler
//   voice_en       : per-voice gate; a low bit makes that voice silent
//   freq_wr_*      : frequency-word write port; freq_wr_clr also zeroes the phase
//   phase_valid/ready : output slot handshake
//   phase_voice    : voice index of the current slot
//   phase_out      : voice phase before this frame's increment
//   phase_wrap     : the increment of this slot overflows the phase word
//   frame_done     : one-cycle pulse after the last voice is accepted
module phase_acc_multi
  import synth_pkg::*;
#(
  parameter int C_VOICES      = C_VOICES_DEFAULT,
  parameter int C_PHASE_WIDTH = C_PHASE_WIDTH_DEFAULT
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         enable,
  input  logic [C_VOICES-1:0]          voice_en,
  input  logic                         freq_wr_en,
  input  logic [$clog2(C_VOICES)-1:0]  freq_wr_addr,
  input  logic [C_PHASE_WIDTH-1:0]     freq_wr_data,
  input  logic                         freq_wr_clr,
  output logic                         phase_valid,
  input  logic                         phase_ready,
  output logic [$clog2(C_VOICES)-1:0]  phase_voice,
  output logic [C_PHASE_WIDTH-1:0]     phase_out,
  output logic                         phase_wrap,
  output logic                         frame_done
);

  localparam int                 C_IDX_W      = $clog2(C_VOICES);
  localparam logic [C_IDX_W-1:0] C_LAST_VOICE = C_IDX_W'(C_VOICES - 1);

  state_t                    state_r;
  state_t                    state_next_s;
  logic                      compute_s;
  logic                      accept_s;

  logic [C_IDX_W-1:0]        v_r;
  logic [C_PHASE_WIDTH-1:0]  phase_mem_r [C_VOICES];
  logic [C_PHASE_WIDTH-1:0]  freq_mem_r  [C_VOICES];
  logic [C_PHASE_WIDTH-1:0]  phase_rd_s;
  logic [C_PHASE_WIDTH-1:0]  freq_rd_s;
  logic [C_PHASE_WIDTH-1:0]  add_sum_s;
  logic                      add_cout_s;

  logic [C_PHASE_WIDTH-1:0]  sum_r;
  logic [C_PHASE_WIDTH-1:0]  phase_out_r;
  logic                      wrap_r;
  logic [C_IDX_W-1:0]        voice_r;
  logic                      valid_r;
  logic                      frame_done_r;

  // Scheduler state register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Scheduler next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (enable) begin
          state_next_s = COMPUTE;
        end else begin
          state_next_s = IDLE;
        end
      end
      COMPUTE: begin
        state_next_s = OUTPUT;
      end
      OUTPUT: begin
        if (!phase_ready) begin
          state_next_s = OUTPUT;
        end else if (enable) begin
          state_next_s = COMPUTE;
        end else begin
          state_next_s = IDLE;
        end
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // Scheduler control strobes.
  always_comb begin
    compute_s = 1'b0;
    accept_s  = 1'b0;
    case (state_r)
      COMPUTE: begin
        compute_s = 1'b1;
      end
      OUTPUT: begin
        if (phase_ready) begin
          accept_s = 1'b1;
        end else begin
          accept_s = 1'b0;
        end
      end
      default: begin
        compute_s = 1'b0;
        accept_s  = 1'b0;
      end
    endcase
  end

  assign phase_rd_s = phase_mem_r[v_r];
  assign freq_rd_s  = freq_mem_r[v_r];

  cl_adder #(
    .C_WIDTH (C_PHASE_WIDTH)
  ) u_adder (
    .a    (phase_rd_s),
    .b    (freq_rd_s),
    .cin  (1'b0),
    .sum  (add_sum_s),
    .cout (add_cout_s)
  );

  // Slot datapath: captured in COMPUTE, held through OUTPUT until the next COMPUTE.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      v_r          <= {C_IDX_W{1'b0}};
      voice_r      <= {C_IDX_W{1'b0}};
      sum_r        <= {C_PHASE_WIDTH{1'b0}};
      phase_out_r  <= {C_PHASE_WIDTH{1'b0}};
      wrap_r       <= 1'b0;
      valid_r      <= 1'b0;
      frame_done_r <= 1'b0;
    end else begin
      valid_r      <= (state_next_s == OUTPUT);
      frame_done_r <= accept_s && (v_r == C_LAST_VOICE);
      if (compute_s) begin
        voice_r <= v_r;
        // A gated voice is silent and its stored phase collapses to zero.
        if (voice_en[v_r]) begin
          phase_out_r <= phase_rd_s;
          sum_r       <= add_sum_s;
          wrap_r      <= add_cout_s;
        end else begin
          phase_out_r <= {C_PHASE_WIDTH{1'b0}};
          sum_r       <= {C_PHASE_WIDTH{1'b0}};
          wrap_r      <= 1'b0;
        end
      end
      if (accept_s) begin
        v_r <= v_r + C_IDX_W'(1);
      end
    end
  end

  // Phase and frequency storage; note-on clear is applied after the
  // writeback so it wins when both target the same voice.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < C_VOICES; i++) begin
        phase_mem_r[i] <= {C_PHASE_WIDTH{1'b0}};
        freq_mem_r[i]  <= {C_PHASE_WIDTH{1'b0}};
      end
    end else begin
      if (accept_s) begin
        phase_mem_r[v_r] <= sum_r;
      end
      if (freq_wr_en) begin
        freq_mem_r[freq_wr_addr] <= freq_wr_data;
        if (freq_wr_clr) begin
          phase_mem_r[freq_wr_addr] <= {C_PHASE_WIDTH{1'b0}};
        end
      end
    end
  end

  assign phase_valid = valid_r;
  assign phase_voice = voice_r;
  assign phase_out   = phase_out_r;
  assign phase_wrap  = wrap_r;
  assign frame_done  = frame_done_r;

endmodule : phase_acc_multi

// File: tb/tb_phase_acc_multi.sv
// Self-checking bench for phase_acc_multi (16 voices, 32-bit phase).
module tb_phase_acc_multi;

  localparam int NV = 16;
  localparam int W  = 32;

  logic          clk;
  logic          reset_n;
  logic          enable;
  logic [NV-1:0] voice_en;
  logic          freq_wr_en;
  logic [3:0]    freq_wr_addr;
  logic [W-1:0]  freq_wr_data;
  logic          freq_wr_clr;
  logic          phase_valid;
  logic          phase_ready;
  logic [3:0]    phase_voice;
  logic [W-1:0]  phase_out;
  logic          phase_wrap;
  logic          frame_done;

  phase_acc_multi #(.C_VOICES(NV), .C_PHASE_WIDTH(W)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .enable       (enable),
    .voice_en     (voice_en),
    .freq_wr_en   (freq_wr_en),
    .freq_wr_addr (freq_wr_addr),
    .freq_wr_data (freq_wr_data),
    .freq_wr_clr  (freq_wr_clr),
    .phase_valid  (phase_valid),
    .phase_ready  (phase_ready),
    .phase_voice  (phase_voice),
    .phase_out    (phase_out),
    .phase_wrap   (phase_wrap),
    .frame_done   (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;
  int fd_seen  = 0;

  // Reference model: per-voice phase/frequency tables plus the slot on offer.
  logic [W-1:0] m_phase [NV];
  logic [W-1:0] m_freq  [NV];
  int           m_mode;      // 0 idle, 1 computing, 2 offering a slot
  int           m_nv;        // next voice to be served
  int           m_acc;       // accepted slots
  logic         m_valid;
  logic         m_fd;
  logic [3:0]   m_voice;
  logic [W-1:0] m_pout;
  logic [W-1:0] m_sum;
  logic         m_wrap;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_assert++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // Advance the model across one clock edge using the inputs now applied.
  task automatic model_edge();
    logic [W:0] s;
    if (!reset_n) begin
      for (int i = 0; i < NV; i++) begin
        m_phase[i] = '0;
        m_freq[i]  = '0;
      end
      m_mode = 0; m_nv = 0; m_valid = 1'b0; m_fd = 1'b0;
      m_voice = '0; m_pout = '0; m_sum = '0; m_wrap = 1'b0;
    end else begin
      m_fd = 1'b0;
      case (m_mode)
        0: if (enable) m_mode = 1;
        1: begin
          s = {1'b0, m_phase[m_nv]} + {1'b0, m_freq[m_nv]};
          m_voice = 4'(m_nv);
          if (voice_en[m_nv]) begin
            m_pout = m_phase[m_nv]; m_sum = s[W-1:0]; m_wrap = s[W];
          end else begin
            m_pout = '0; m_sum = '0; m_wrap = 1'b0;
          end
          m_valid = 1'b1;
          m_mode  = 2;
        end
        2: if (phase_ready) begin
          m_phase[m_nv] = m_sum;
          m_fd    = (m_nv == NV - 1);
          m_nv    = (m_nv + 1) % NV;
          m_acc++;
          m_valid = 1'b0;
          m_mode  = enable ? 1 : 0;
        end
        default: m_mode = 0;
      endcase
      if (freq_wr_en) begin
        m_freq[freq_wr_addr] = freq_wr_data;
        if (freq_wr_clr) m_phase[freq_wr_addr] = '0;
      end
    end
  endtask

  task automatic check_outputs();
    chk("valid",      {63'd0, phase_valid}, {63'd0, m_valid});
    chk("frame_done", {63'd0, frame_done},  {63'd0, m_fd});
    chk("voice",      {60'd0, phase_voice}, {60'd0, m_voice});
    chk("phase_out",  {32'd0, phase_out},   {32'd0, m_pout});
    chk("wrap",       {63'd0, phase_wrap},  {63'd0, m_wrap});
    if (frame_done === 1'b1) fd_seen++;
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic wait_voice(input int n);
    int k = 0;
    while (!(m_valid && m_voice == 4'(n)) && k < 100) begin
      tick();
      k++;
    end
    chk("wait_voice", {59'd0, phase_valid, phase_voice}, {59'd0, 1'b1, 4'(n)});
  endtask

  task automatic wr_freq(input int a, input logic [W-1:0] d, input logic clr);
    freq_wr_en = 1'b1; freq_wr_addr = 4'(a); freq_wr_data = d; freq_wr_clr = clr;
    tick();
    freq_wr_en = 1'b0; freq_wr_clr = 1'b0;
  endtask

  logic [W-1:0] exp35 [5];
  int           acc0;
  int           kk;

  initial begin
    exp35[0] = 32'h0000_0000; exp35[1] = 32'h4000_0000; exp35[2] = 32'h8000_0000;
    exp35[3] = 32'hC000_0000; exp35[4] = 32'h0000_0000;
    reset_n = 1'b0; enable = 1'b0; voice_en = '1; phase_ready = 1'b1;
    freq_wr_en = 1'b0; freq_wr_addr = '0; freq_wr_data = '0; freq_wr_clr = 1'b0;
    m_acc = 0;

    // Reset state.
    tick(); tick();
    reset_n = 1'b1;
    tick();

    // Voice 0 steps by a quarter turn; voice 3 gets a small step for the clear test.
    wr_freq(0, 32'h4000_0000, 1'b0);
    wr_freq(3, 32'h0000_0100, 1'b0);
    enable = 1'b1;
    for (int f = 0; f < 5; f++) begin
      wait_voice(0);
      chk("v0_phase", {32'd0, phase_out}, {32'd0, exp35[f]});
      chk("v0_wrap",  {63'd0, phase_wrap}, {63'd0, (f == 3)});
      tick();
    end

    // Back-pressure: hold voice 7 for five cycles.
    wait_voice(7);
    phase_ready = 1'b0;
    repeat (5) begin
      tick();
      chk("hold_voice", {59'd0, phase_valid, phase_voice}, {59'd0, 1'b1, 4'd7});
    end
    phase_ready = 1'b1;
    tick();
    tick();
    chk("after_hold", {59'd0, phase_valid, phase_voice}, {59'd0, 1'b1, 4'd8});

    // Note-on clear of voice 3 in its own acceptance cycle.
    wait_voice(3);
    wr_freq(3, 32'h0000_1234, 1'b1);
    wait_voice(3);
    chk("clr_phase0", {32'd0, phase_out}, 64'd0);
    tick();
    wait_voice(3);
    chk("clr_newinc", {32'd0, phase_out}, 64'h1234);
    tick();

    // Pause during voice 5 and resume at voice 6 with two-cycle latency.
    wait_voice(5);
    enable = 1'b0;
    tick();
    repeat (3) tick();
    chk("paused", {63'd0, phase_valid}, 64'd0);
    enable = 1'b1;
    tick();
    chk("resume_lat", {63'd0, phase_valid}, 64'd0);
    tick();
    chk("resume", {59'd0, phase_valid, phase_voice}, {59'd0, 1'b1, 4'd6});

    // Gated voice 2 and one frame_done per 16 accepts.
    voice_en[2] = 1'b0;
    wr_freq(2, 32'h0000_1000, 1'b0);
    wait_voice(0);
    fd_seen = 0;
    acc0 = m_acc;
    kk = 0;
    while (m_acc - acc0 < 48 && kk < 400) begin
      tick();
      if (m_valid && m_voice == 4'd2) chk("gated_v2", {31'd0, phase_wrap, phase_out}, 64'd0);
      kk++;
    end
    tick();
    chk("frame_done_count", 64'(fd_seen), 64'd3);
    voice_en = '1;

    // Reset while a slot is on offer.
    wait_voice(9);
    reset_n = 1'b0;
    tick();
    chk("reset_drop", {63'd0, phase_valid}, 64'd0);
    tick();
    reset_n = 1'b1;
    repeat (33) begin
      tick();
      if (m_valid) chk("post_reset_zero", {32'd0, phase_out}, 64'd0);
    end

    // Randomized traffic against the model.
    for (int i = 0; i < 800; i++) begin
      enable      = ($urandom_range(0, 9) != 0);
      phase_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 31) == 0)
        voice_en = ($urandom_range(0, 1) == 0) ? NV'($urandom) : '1;
      freq_wr_en   = ($urandom_range(0, 3) == 0);
      freq_wr_clr  = ($urandom_range(0, 7) == 0);
      freq_wr_addr = 4'($urandom_range(0, NV - 1));
      freq_wr_data = ($urandom_range(0, 1) == 0) ? $urandom : 32'($urandom_range(0, 65535)) << 16;
      tick();
    end
    freq_wr_en = 1'b0; freq_wr_clr = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule : tb_phase_acc_multi
